// File: rtl/aud_dac_serializer_pkg.sv
// rtl/aud_dac_serializer_pkg.sv - shared types and defaults for the audio DAC serializer
package aud_dac_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_BCLK_DIV  = 16;
  localparam int DEF_WORD_W    = 16;
  localparam int DEF_FRAME_LEN = 2 * DEF_WORD_W;

endpackage

// File: rtl/aud_bclk_gen.sv
// rtl/aud_bclk_gen.sv - BCLK divider with one-cycle rise/fall strobes
module aud_bclk_gen
  import aud_dac_serializer_pkg::*;
#(
  parameter int BCLK_DIV = DEF_BCLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] TC = 8'(BCLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       bclk_q, bclk_d;
  logic       tc;

  always_comb begin
    tc     = (div_q == TC);
    div_d  = tc ? 8'd0 : div_q + 8'd1;
    bclk_d = bclk_q ^ tc;
    if (hold) begin
      div_d  = 8'd0;
      bclk_d = 1'b0;
    end
  end

  // Strobes mark the cycle whose clock edge moves BCLK.
  assign rise = tc & ~bclk_q & ~hold;
  assign fall = tc & bclk_q & ~hold;
  assign bclk = bclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 8'd0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/aud_dac_serializer.sv
// rtl/aud_dac_serializer.sv - sample-pair buffer and codec serializer (codec as slave)
// AUD_I2S_MODE_EN selects Philips I2S framing; left-justified otherwise.
module aud_dac_serializer
  import aud_dac_serializer_pkg::*;
#(
  parameter int BCLK_DIV = DEF_BCLK_DIV,
  parameter int WORD_W   = DEF_WORD_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [WORD_W-1:0] LData,
  input  logic [WORD_W-1:0] RData,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              FRAME_START,
  output logic              UNDERRUN
);

  localparam int FRAME_LEN = DEF_FRAME_LEN / DEF_WORD_W * WORD_W;
  localparam int BIT_W     = $clog2(FRAME_LEN);
`ifdef AUD_I2S_MODE_EN
  localparam int SH_W = FRAME_LEN + 1;
`else
  localparam int SH_W = FRAME_LEN;
`endif
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0] HALF     = BIT_W'(WORD_W);

  state_t               state_q, state_d;
  logic                 full_q, full_d;
  logic [FRAME_LEN-1:0] buf_q, buf_d;
  logic [SH_W-1:0]      sh_q, sh_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 framing_q, framing_d;
  logic                 tail_q, tail_d;
  logic                 stop_q, stop_d;
  logic                 lrck_q, lrck_d;
  logic                 dat_q, dat_d;
  logic                 fs_q, fs_d;
  logic                 und_q, und_d;

  logic                 bclk, bclk_rise, bclk_fall, hold;
  logic                 hs, boundary, load;
  logic [FRAME_LEN-1:0] word;
  logic [SH_W-1:0]      sh_pre;

  function automatic logic lrck_for(input logic [BIT_W-1:0] idx);
`ifdef AUD_I2S_MODE_EN
    return idx >= HALF;
`else
    return idx < HALF;
`endif
  endfunction

  assign hold = (state_q == IDLE);

  aud_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk   (CLK),
    .rst_n (RESET_N),
    .hold  (hold),
    .bclk  (bclk),
    .rise  (bclk_rise),
    .fall  (bclk_fall)
  );

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    buf_d     = buf_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    framing_d = framing_q;
    tail_d    = tail_q;
    stop_d    = stop_q;
    lrck_d    = lrck_q;
    dat_d     = dat_q;
    fs_d      = 1'b0;
    und_d     = und_q;
    load      = 1'b0;
    hs        = IN_VALID & ~full_q;
    // The first fall after leaving IDLE is treated as a frame boundary.
    boundary  = bclk_fall & (~framing_q | (bit_q == LAST_BIT));
    word      = full_q ? buf_q : '0;
`ifdef AUD_I2S_MODE_EN
    sh_pre    = {sh_q[SH_W-1], word};
`else
    sh_pre    = word;
`endif

    case (state_q)
      IDLE: begin
        bit_d     = '0;
        framing_d = 1'b0;
        tail_d    = 1'b0;
        stop_d    = 1'b0;
        lrck_d    = 1'b0;
        dat_d     = 1'b0;
        sh_d      = '0;
        if (ENABLE) state_d = RUN;
      end
      RUN: begin
        // Stop decision is taken half a bit ahead of the boundary it applies to.
        if (bclk_rise) stop_d = ~ENABLE;
        if (tail_q) begin
          if (bclk_fall) begin
            state_d = IDLE;
            lrck_d  = 1'b0;
            dat_d   = 1'b0;
          end
        end else if (boundary) begin
          bit_d = '0;
          if (stop_q) begin
`ifdef AUD_I2S_MODE_EN
            tail_d = 1'b1;
            dat_d  = sh_q[SH_W-1];
            lrck_d = lrck_for('0);
`else
            state_d = IDLE;
            lrck_d  = 1'b0;
            dat_d   = 1'b0;
`endif
          end else begin
            load      = 1'b1;
            framing_d = 1'b1;
            fs_d      = 1'b1;
            if (!full_q) und_d = 1'b1;
            dat_d     = sh_pre[SH_W-1];
            sh_d      = sh_pre << 1;
            lrck_d    = lrck_for('0);
          end
        end else if (bclk_fall) begin
          bit_d  = bit_q + 1'b1;
          dat_d  = sh_q[SH_W-1];
          sh_d   = sh_q << 1;
          lrck_d = lrck_for(bit_d);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) full_d = 1'b0;
    if (hs) begin
      full_d = 1'b1;
      buf_d  = {LData, RData};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      full_q    <= 1'b0;
      buf_q     <= '0;
      sh_q      <= '0;
      bit_q     <= '0;
      framing_q <= 1'b0;
      tail_q    <= 1'b0;
      stop_q    <= 1'b0;
      lrck_q    <= 1'b0;
      dat_q     <= 1'b0;
      fs_q      <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      buf_q     <= buf_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      framing_q <= framing_d;
      tail_q    <= tail_d;
      stop_q    <= stop_d;
      lrck_q    <= lrck_d;
      dat_q     <= dat_d;
      fs_q      <= fs_d;
      und_q     <= und_d;
    end
  end

  assign IN_READY    = ~full_q;
  assign AUD_BCLK    = bclk;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;
  assign FRAME_START = fs_q;
  assign UNDERRUN    = und_q;

endmodule

// File: tb/tb_aud_dac_serializer.sv
// tb/tb_aud_dac_serializer.sv - self-checking bench for aud_dac_serializer
module tb_aud_dac_serializer;

  localparam int DIV = 4;
  localparam int W   = 16;
  localparam int FL  = 2 * W;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         ENABLE = 1'b0;
  logic         IN_VALID = 1'b0;
  logic [W-1:0] LData = '0;
  logic [W-1:0] RData = '0;
  logic         IN_READY, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, FRAME_START, UNDERRUN;

  aud_dac_serializer #(.BCLK_DIV(DIV), .WORD_W(W)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .LData       (LData),
    .RData       (RData),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .FRAME_START (FRAME_START),
    .UNDERRUN    (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic cap_lr[$];
  logic cap_dat[$];
  int   fs_cyc[$];
  int   fs_high = 0;
  int   tog_cyc[$];
  logic prev_bclk = 1'b0;
  logic prev_fs = 1'b0;

  // Passive observer: what the codec sees at each BCLK rise, plus edge timing.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (AUD_BCLK !== prev_bclk) tog_cyc.push_back(cyc);
    if (AUD_BCLK === 1'b1 && prev_bclk === 1'b0) begin
      cap_lr.push_back(AUD_DACLRCK);
      cap_dat.push_back(AUD_DACDAT);
    end
    if (FRAME_START === 1'b1) begin
      fs_high = fs_high + 1;
      if (prev_fs !== 1'b1) fs_cyc.push_back(cyc);
    end
    prev_fs   = FRAME_START;
    prev_bclk = AUD_BCLK;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    cap_lr.delete();
    cap_dat.delete();
    fs_cyc.delete();
    tog_cyc.delete();
    fs_high = 0;
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r, input string tag);
    int n;
    n = 0;
    IN_VALID = 1'b1;
    LData = l;
    RData = r;
    while (IN_READY !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    chk(tag, IN_READY, 1'b1);
    tick(1);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_fs(input int n, input string tag);
    int t;
    t = 0;
    while (fs_cyc.size() < n && t < 4000) begin
      tick(1);
      t++;
    end
    chk(tag, fs_cyc.size() >= n, 1'b1);
  endtask

  // Expected codec view: one idle sample before the first load, then the frames
  // as one MSB-first bit stream (I2S: delayed by one bit, trailing LSB sent at stop).
  task automatic check_stream(input string tag, input logic [FL-1:0] frames[$],
                              input int n_cmp, input bit stopped);
    logic ds[$];
    int   n, k;
    logic e_lr, e_dat;
`ifdef AUD_I2S_MODE_EN
    ds.push_back(1'b0);
`endif
    foreach (frames[f]) for (int b = FL - 1; b >= 0; b--) ds.push_back(frames[f][b]);
    if (stopped) begin
      n = 1 + ds.size();
      chk({tag, "_len"}, cap_dat.size(), n);
    end else begin
      n = n_cmp;
      chk({tag, "_avail"}, cap_dat.size() >= n, 1'b1);
    end
    if (cap_dat.size() < n) n = cap_dat.size();
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        e_lr  = 1'b0;
        e_dat = 1'b0;
      end else begin
        k     = i - 1;
        e_dat = ds[k];
`ifdef AUD_I2S_MODE_EN
        e_lr  = (k % FL) >= W;
`else
        e_lr  = (k % FL) < W;
`endif
      end
      chk($sformatf("%s_bit%0d", tag, i), {cap_lr[i], cap_dat[i]}, {e_lr, e_dat});
    end
  endtask

  initial begin
    logic [FL-1:0] words_a[$];
    logic [FL-1:0] words_b[$];
    logic [W-1:0]  l, r;
    int            en_cyc, ntog, bad;

    // Reset and idle behaviour
    tick(2);
    chk("rst_bclk", AUD_BCLK, 1'b0);
    chk("rst_lrck", AUD_DACLRCK, 1'b0);
    chk("rst_dat", AUD_DACDAT, 1'b0);
    chk("rst_fs", FRAME_START, 1'b0);
    chk("rst_und", UNDERRUN, 1'b0);
    chk("rst_ready", IN_READY, 1'b1);
    RESET_N = 1'b1;
    tick(1);
    clear_capture();
    tick(1000);
    chk("idle_toggles", tog_cyc.size(), 0);
    chk("idle_fs", fs_high, 0);
    chk("idle_lrck", AUD_DACLRCK, 1'b0);
    chk("idle_ready", IN_READY, 1'b1);

    // Session A: preloaded pair, back-to-back pushes, stop requested mid-frame
    push(16'hA5F0, 16'h0F5A, "push_a0");
    words_a.push_back({16'hA5F0, 16'h0F5A});
    chk("idle_buffer_full", IN_READY, 1'b0);
    chk("idle_bclk_still", AUD_BCLK, 1'b0);
    ENABLE = 1'b1;
    en_cyc = cyc;
    for (int p = 1; p <= 4; p++) begin
      l = W'($urandom);
      r = W'($urandom);
      push(l, r, $sformatf("push_a%0d", p));
      words_a.push_back({l, r});
      chk($sformatf("ready_low_a%0d", p), IN_READY, 1'b0);
    end
    wait_fs(5, "wait_fs5");
    chk("first_load_latency",
        (fs_cyc[0] - en_cyc >= 2 * DIV) && (fs_cyc[0] - en_cyc <= 2 * DIV + 2), 1'b1);
    tick(5 * 2 * DIV + 2);
    ENABLE = 1'b0;
    tick(2 * FL * DIV);
    chk("stop_bclk", AUD_BCLK, 1'b0);
    chk("stop_lrck", AUD_DACLRCK, 1'b0);
    chk("stop_dat", AUD_DACDAT, 1'b0);
    chk("stop_und", UNDERRUN, 1'b0);
    chk("fs_count", fs_cyc.size(), 5);
    chk("fs_width", fs_high, 5);
    for (int i = 1; i < fs_cyc.size(); i++)
      chk($sformatf("fs_spacing%0d", i), fs_cyc[i] - fs_cyc[i-1], 2 * FL * DIV);
    bad = 0;
    for (int i = 1; i < tog_cyc.size(); i++)
      if (tog_cyc[i] - tog_cyc[i-1] != DIV) bad++;
    chk("bclk_half_period", bad, 0);
    ntog = tog_cyc.size();
    tick(100);
    chk("stopped_no_toggle", tog_cyc.size(), ntog);
    check_stream("a", words_a, 0, 1'b1);

    // Session B: underrun, sticky flag, asynchronous reset mid-frame
    RESET_N = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(2);
    clear_capture();
    ENABLE = 1'b1;
    tick(3);
    chk("und_before_load", UNDERRUN, 1'b0);
    wait_fs(1, "wait_fs_b1");
    chk("und_set", UNDERRUN, 1'b1);
    words_b.push_back('0);
    l = W'($urandom);
    r = W'($urandom);
    push(l, r, "push_b1");
    words_b.push_back({l, r});
    push(W'($urandom), W'($urandom), "push_b2");
    chk("und_sticky", UNDERRUN, 1'b1);
    chk("fs_count_b", fs_cyc.size(), 2);
    tick(20 * 2 * DIV + 3);
    chk("b_buffer_full", IN_READY, 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_bclk", AUD_BCLK, 1'b0);
    chk("arst_lrck", AUD_DACLRCK, 1'b0);
    chk("arst_dat", AUD_DACDAT, 1'b0);
    chk("arst_fs", FRAME_START, 1'b0);
    chk("arst_und", UNDERRUN, 1'b0);
    chk("arst_ready", IN_READY, 1'b1);
    check_stream("b", words_b, 1 + FL + W, 1'b0);
    ENABLE = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(5);
    chk("post_rst_empty", IN_READY, 1'b1);
    chk("post_rst_bclk", AUD_BCLK, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
